tt_rr_arbiter_ctrl: RTL
=======================

Name: tt_rr_arbiter_ctrl

Overview:
- Round-robin arbiter and scheduler that shares one downstream resource between three requesters. The resource is, for example, the shared storage cell or latch bank on the same tile.
- The block sits on the standard 8-in/8-out tile pinout and issues one-hot, registered grants.
- Each grant is held until the holder releases it or a hold timeout expires.
- A sticky flag records any forced revoke.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles a grant may be held before it is force-revoked. Legal range is 2..15; the counter is 4 bits.

Ports:
- io_in[0]  input  1  clk: the single clock, rising edge.
- io_in[1]  input  1  reset: synchronous, active-high.
- io_in[4:2]  input  3  req[2:0]: level requests, one per requester.
- io_in[5]  input  1  rel: release pulse from the current holder, sampled on clk.
- io_in[6]  input  1  en: arbitration enable. When low, no new grants are issued; an existing grant is kept.
- io_in[7]  input  1  lock: while high, the holder is exempt from the timeout.
- io_out[2:0]  output  3  gnt[2:0]: one-hot grant, registered.
- io_out[3]  output  1  busy: high when in GRANT or GAP.
- io_out[5:4]  output  2  gnt_id: index of the holder; 2'b11 when there is no holder.
- io_out[6]  output  1  tmo: one-cycle pulse on a forced revoke.
- io_out[7]  output  1  tmo_sticky: set by any forced revoke; cleared only by reset.

Behaviour:
- Reset (synchronous, io_in[1]=1 at a clk edge):
  - Outputs: gnt=000, busy=0, gnt_id=11, tmo=0, tmo_sticky=0.
  - Internal state: FSM=IDLE, last pointer=2 (so requester 0 has first priority), hold counter=0.
  - Reset wins over every other event in the same cycle, including mid-grant: the grant drops on the cycle after reset is sampled.
- FSM states: IDLE, GRANT, GAP. All outputs are registered.
- IDLE:
  - If en=1 and req!=0, pick the first set req scanning last+1, last+2, last+3 (mod 3).
  - Next cycle: gnt=onehot(winner), gnt_id=winner, busy=1, last<=winner, counter<=0, state GRANT.
  - Latency from a req sampled high to gnt high is 1 cycle.
- GRANT: the counter increments every cycle and saturates at MAX_HOLD. Exit conditions, in priority order:
  - a) rel=1, or the holder's req=0: normal release. Next cycle gnt=000, gnt_id=11, state GAP.
  - b) lock=0 and counter==MAX_HOLD-1: forced revoke. Next cycle gnt=000, gnt_id=11, tmo=1 for exactly one cycle, tmo_sticky=1, state GAP.
  - If a) and b) coincide, a) wins and tmo is not asserted.
  - With lock=1 the counter saturates and no revoke occurs. If lock drops while counter==MAX_HOLD, revoke on the next edge.
  - Requests from non-holders are ignored while in GRANT.
- GAP:
  - Exactly one cycle with gnt=000 and busy=1, then IDLE.
  - The earliest next grant is therefore 2 cycles after the release or revoke edge. This is a mandatory dead cycle so the shared resource sees clean handover.
- en=0 blocks only the IDLE->GRANT transition. Release and timeout still operate.
- The pointer advances only when a grant is issued, so a revoked holder moves to lowest priority.
- gnt is never multi-hot. gnt_id always equals the encoded gnt, or 11 when gnt=000.

Test Plan:
- Reset, then req=001, en=1 → gnt=001 and gnt_id=00 one cycle later, busy=1. Then rel pulse → gnt=000 next cycle, GAP for 1 cycle, IDLE.
- req=111 held, rel pulsed whenever granted → grant order 0,1,2,0,1,2, with 2 idle cycles between consecutive grants (GAP then IDLE).
- req=010 held, no rel, lock=0, MAX_HOLD=8 → gnt=010 for 8 cycles, then gnt=000 with tmo=1 for one cycle. tmo_sticky=1 persists through later grants until reset.
- Same as above with lock=1 for 20 cycles → no revoke, tmo_sticky stays 0. Drop lock → revoke on the next edge and tmo pulses.
- en=0 with req=101 → gnt stays 000. Raise en → gnt=001 next cycle. Drop en while granted → grant is kept until rel.
- Assert reset mid-GRANT (gnt=100) → next cycle gnt=000, gnt_id=11, tmo_sticky=0. Then req=111 → requester 0 is granted first.

Source files
------------

// File: rtl/tt_rr_arbiter_ctrl.sv
// Three-way round-robin arbiter for a shared tile resource: registered one-hot
// grants, hold timeout with lock override, and a mandatory dead cycle between grants.
module tt_rr_arbiter_ctrl #(
  parameter int MAX_HOLD = 8
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
  localparam logic [3:0] HOLD_SAT  = 4'(MAX_HOLD);

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic       rel;
  logic       en;
  logic       lock;

  assign clk  = io_in[0];
  assign rst  = io_in[1];
  assign req  = io_in[4:2];
  assign rel  = io_in[5];
  assign en   = io_in[6];
  assign lock = io_in[7];

  state_t     state, state_n;
  logic [2:0] gnt, gnt_n;
  logic [1:0] gnt_id, gnt_id_n;
  logic [1:0] last, last_n;
  logic [3:0] cnt, cnt_n;
  logic       tmo, tmo_n;
  logic       tmo_sticky, tmo_sticky_n;
  logic [1:0] winner;
  logic       holder_req;

  // Scan ptr+1, ptr+2, ptr+3 (mod 3); 2'b11 means no request is pending.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
    logic [3:0] rx;
    logic [1:0] p;
    rr_pick = 2'b11;
    rx      = {1'b0, r};
    p       = ptr;
    for (int i = 0; i < 3; i++) begin
      p = (p == 2'd2) ? 2'd0 : p + 2'd1;
      if (rx[p] && (rr_pick == 2'b11)) rr_pick = p;
    end
  endfunction

  assign winner     = rr_pick(req, last);
  assign holder_req = |(req & gnt);

  always_comb begin
    state_n      = state;
    gnt_n        = gnt;
    gnt_id_n     = gnt_id;
    last_n       = last;
    cnt_n        = cnt;
    tmo_n        = 1'b0;
    tmo_sticky_n = tmo_sticky;
    case (state)
      IDLE: begin
        if (en && (req != 3'b000)) begin
          state_n  = GRANT;
          gnt_n    = 3'b001 << winner;
          gnt_id_n = winner;
          last_n   = winner;
          cnt_n    = 4'd0;
        end
      end
      GRANT: begin
        cnt_n = (cnt == HOLD_SAT) ? cnt : cnt + 4'd1;
        // Voluntary release outranks the timeout, so no tmo pulse when both hit.
        if (rel || !holder_req) begin
          state_n  = GAP;
          gnt_n    = 3'b000;
          gnt_id_n = 2'b11;
        end else if (!lock && (cnt >= HOLD_LAST)) begin
          state_n      = GAP;
          gnt_n        = 3'b000;
          gnt_id_n     = 2'b11;
          tmo_n        = 1'b1;
          tmo_sticky_n = 1'b1;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 3'b000;
      gnt_id     <= 2'b11;
      last       <= 2'd2;
      cnt        <= 4'd0;
      tmo        <= 1'b0;
      tmo_sticky <= 1'b0;
    end else begin
      state      <= state_n;
      gnt        <= gnt_n;
      gnt_id     <= gnt_id_n;
      last       <= last_n;
      cnt        <= cnt_n;
      tmo        <= tmo_n;
      tmo_sticky <= tmo_sticky_n;
    end
  end

  assign io_out = {tmo_sticky, tmo, gnt_id, (state != IDLE), gnt};

endmodule
